relu_maxpool_flatten: RTL and testbench

Upstream feeder for the dense-layer accelerator. Consumes a single-channel Q-format feature map as a raster-order pixel stream and applies ReLU and 2x2 stride-2 max pooling. Emits the flattened pooled vector as indexed writes, in the exact order and width the dense stage's feature memory expects. FLAT_SIZE = (IN_H/2)*(IN_W/2) equals the dense stage's FLAT_SIZE.

---
 rtl/cnn_pkg.sv | 35 +++
 rtl/pool_line_buffer.sv | 42 ++++
 rtl/relu_maxpool_flatten.sv | 187 ++++++++++++++++++
 tb/tb_relu_maxpool_flatten.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: word-width defaults, flattened-vector size
// derivation, index-width helper, pooling FSM states and a signed max.
// Imported by the pooling front end and the dense accelerator so that the
// flattened vector length is derived in exactly one place.
package cnn_pkg;

  localparam int unsigned CNN_N  = 16;
  localparam int unsigned CNN_Q  = 8;
  localparam int unsigned WIDE_W = 64;

  // Wide signed carrier so one max function serves any N up to WIDE_W.
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } pool_state_e;

  // Length of the flattened vector after 2x2 stride-2 pooling.
  function automatic int unsigned flat_size(input int unsigned h, input int unsigned w);
    return (h / 2) * (w / 2);
  endfunction

  // Address width for an n-entry space; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed maximum; callers sign-extend into wide_t and truncate back.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Holds the horizontal pair maxima of an even row until the matching odd row
// arrives. One register per output column.
// Ports: clk, clear_n (sync active-low clear), wr_en/wr_addr/wr_data (even
// rows), rd_addr/rd_data_c (combinational read, odd rows).
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned N     = CNN_N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data_c
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];

  // Write port next-state.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/relu_maxpool_flatten.sv
// ReLU + 2x2 stride-2 max pooling over a raster-order single-channel map,
// emitting the flattened pooled vector as indexed writes for the dense stage.
// Ports: clk, reset (sync active-low); start/busy/done frame control;
// in_valid/in_ready/in_data pixel stream; out_valid/out_ready/out_idx/out_data
// flattened element writes (single-entry output register).
module relu_maxpool_flatten
  import cnn_pkg::*;
#(
  parameter  int unsigned N         = CNN_N,
  parameter  int unsigned Q         = CNN_Q,
  parameter  int unsigned IN_H      = 8,
  parameter  int unsigned IN_W      = 8,
  localparam int unsigned FLAT_SIZE = flat_size(IN_H, IN_W),
  localparam int unsigned IDX_W     = idx_width(FLAT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_data
);

  localparam int unsigned RW     = idx_width(IN_H);
  localparam int unsigned CW     = idx_width(IN_W);
  localparam int unsigned HALF_W = IN_W / 2;
  localparam int unsigned AW     = idx_width(HALF_W);

  // Elaboration-time geometry checks.
  if ((IN_H < 2) || ((IN_H % 2) != 0)) begin : g_bad_h
    $error("relu_maxpool_flatten: IN_H must be even and >= 2");
  end
  if ((IN_W < 2) || ((IN_W % 2) != 0)) begin : g_bad_w
    $error("relu_maxpool_flatten: IN_W must be even and >= 2");
  end
  if (Q >= N) begin : g_bad_q
    $error("relu_maxpool_flatten: Q must be smaller than N");
  end

  pool_state_e              state_q, state_d;
  logic        [RW-1:0]     r_q, r_d;
  logic        [CW-1:0]     c_q, c_d;
  logic signed [N-1:0]      h_q, h_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic        [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic        [N-1:0]      out_data_q, out_data_d;

  logic                     accept_c;
  logic signed [N-1:0]      pix_c;
  logic signed [N-1:0]      pair_c;
  logic signed [N-1:0]      lb_rd_c;
  logic signed [N-1:0]      win_max_c;
  logic        [AW-1:0]     lb_addr_c;
  logic                     lb_wr_en_c;
  logic        [N-1:0]      lb_rd_raw_c;

  // Stall the input whenever the output register holds an unaccepted element.
  assign in_ready = (state_q == S_RUN) && !(out_valid_q && !out_ready);
  assign accept_c = in_valid && in_ready;

  assign pix_c     = $signed(in_data);
  assign pair_c    = N'(smax(wide_t'(h_q), wide_t'(pix_c)));
  assign lb_rd_c   = $signed(lb_rd_raw_c);
  assign win_max_c = N'(smax(wide_t'(lb_rd_c), wide_t'(pair_c)));
  assign lb_addr_c = AW'(c_q >> 1);

  pool_line_buffer #(
    .N     (N),
    .DEPTH (HALF_W),
    .AW    (AW)
  ) u_line_buf (
    .clk       (clk),
    .clear_n   (reset),
    .wr_en     (lb_wr_en_c),
    .wr_addr   (lb_addr_c),
    .wr_data   (pair_c),
    .rd_addr   (lb_addr_c),
    .rd_data_c (lb_rd_raw_c)
  );

  // Next-state, counters and pooling datapath.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    h_d         = h_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    lb_wr_en_c  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          r_d     = '0;
          c_d     = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (accept_c) begin
          if (!c_q[0]) begin
            h_d = pix_c;
          end else if (!r_q[0]) begin
            lb_wr_en_c = 1'b1;
          end else begin
            // Bottom-right pixel of a window: ReLU the pooled maximum.
            out_valid_d = 1'b1;
            out_data_d  = win_max_c[N-1] ? '0 : win_max_c;
            out_idx_d   = IDX_W'(IDX_W'(r_q >> 1) * IDX_W'(HALF_W) + IDX_W'(c_q >> 1));
          end

          if (c_q == CW'(IN_W - 1)) begin
            c_d = '0;
            if (r_q == RW'(IN_H - 1)) begin
              r_d     = '0;
              state_d = S_DRAIN;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      h_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      h_q         <= h_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_relu_maxpool_flatten.sv
// Directed bench for relu_maxpool_flatten on an 8x8 map (16 pooled outputs).
module tb_relu_maxpool_flatten;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  relu_maxpool_flatten #(
    .N    (16),
    .Q    (8),
    .IN_H (8),
    .IN_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] pix   [64];
  logic [15:0] exp_d [16];
  logic [15:0] got_d [$];
  int          got_i [$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;
  int          done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe output transfers and done pulses mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_i.push_back(int'(out_idx));
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: direct 2x2 window maximum followed by ReLU.
  function automatic void build_model();
    for (int pr = 0; pr < 4; pr++) begin
      for (int pc = 0; pc < 4; pc++) begin
        logic signed [15:0] m;
        logic signed [15:0] v;
        m = $signed(pix[(2*pr)*8 + 2*pc]);
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = $signed(pix[(2*pr+dr)*8 + 2*pc+dc]);
            if (v > m) m = v;
          end
        end
        if (m < 0) m = 16'sd0;
        exp_d[pr*4+pc] = m;
      end
    end
  endfunction

  task automatic clear_obs();
    got_d.delete();
    got_i.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_pix(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pixels(input bit gaps, input bit mid_start, input int count);
    for (int i = 0; i < count; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (mid_start && (i == 30)) pulse_start();
      push_pix(pix[i]);
    end
  endtask

  task automatic finish_frame(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    check($sformatf("%s_done_cnt", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s_done_lat", tag), 32'(done_cyc - last_xfer_cyc), 32'd1);
    check($sformatf("%s_n_out", tag), 32'(got_d.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_d.size()) begin
        check($sformatf("%s_idx%0d", tag, i), 32'(got_i[i]), 32'(i));
        check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      end
    end
    @(negedge clk);
    check($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) pix[i] = 16'(i * 16);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, continuous flow.
    load_ramp();
    build_model();
    clear_obs();
    pulse_start();
    check("ramp_busy", 32'(busy), 32'd1);
    send_pixels(1'b0, 1'b0, 64);
    finish_frame("ramp");
    if (got_d.size() == 16) begin
      check("ramp_hand_idx0", 32'(got_d[0]), 32'h0090);
      check("ramp_hand_idx15", 32'(got_d[15]), 32'h03F0);
    end

    // All negative except one positive pixel at r=5, c=2.
    for (int i = 0; i < 64; i++) pix[i] = 16'hFF00;
    pix[5*8+2] = 16'h0080;
    build_model();
    clear_obs();
    pulse_start();
    send_pixels(1'b0, 1'b0, 64);
    finish_frame("neg");
    if (got_d.size() == 16) begin
      check("neg_hand_idx9", 32'(got_d[9]), 32'h0080);
      check("neg_hand_idx8", 32'(got_d[8]), 32'h0000);
    end

    // Most-negative and most-positive values in one window.
    for (int i = 0; i < 64; i++) pix[i] = 16'h8000;
    pix[1] = 16'h7FFF;
    pix[8] = 16'h8001;
    build_model();
    clear_obs();
    pulse_start();
    send_pixels(1'b0, 1'b0, 64);
    finish_frame("sgn");
    if (got_d.size() == 16) begin
      check("sgn_hand_idx0", 32'(got_d[0]), 32'h7FFF);
      check("sgn_hand_idx1", 32'(got_d[1]), 32'h0000);
    end

    // Ramp with a 5-cycle consumer stall on idx 3.
    load_ramp();
    build_model();
    clear_obs();
    pulse_start();
    fork
      send_pixels(1'b0, 1'b0, 64);
      begin
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 600; k++) begin
          @(posedge clk); #1;
          if (out_valid && (out_idx == 4'd3)) begin
            hit = 1'b1;
            break;
          end
        end
        check("stall_seen", 32'(hit), 32'd1);
        if (hit) begin
          out_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_idx", 32'(out_idx), 32'd3);
            check("stall_out_data", 32'(out_data), 32'h00F0);
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    join
    finish_frame("stall");

    // Reset mid-frame after 20 pixels, then a clean frame.
    load_ramp();
    build_model();
    clear_obs();
    pulse_start();
    send_pixels(1'b0, 1'b0, 20);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_idx", 32'(out_idx), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    clear_obs();
    pulse_start();
    send_pixels(1'b0, 1'b0, 64);
    finish_frame("post_rst");

    // Random pixels, input gaps, and a start pulse while busy.
    for (int i = 0; i < 64; i++) pix[i] = 16'($urandom);
    build_model();
    clear_obs();
    pulse_start();
    send_pixels(1'b1, 1'b1, 64);
    finish_frame("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
